// File: rtl/parking_pkg.sv
// parking_pkg: shared FSM states, direction codes and beam phase patterns.
package parking_pkg;
  typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, GAP} state_t;
  localparam logic DIR_ENTER = 1'b0;
  localparam logic DIR_EXIT = 1'b1;
  localparam logic [1:0] ENTER_PH1 = 2'b10;
  localparam logic [1:0] ENTER_PH2 = 2'b11;
  localparam logic [1:0] ENTER_PH3 = 2'b01;
  localparam logic [1:0] EXIT_PH1 = 2'b01;
  localparam logic [1:0] EXIT_PH2 = 2'b11;
  localparam logic [1:0] EXIT_PH3 = 2'b10;
  // A balking car backs out, so its third phase replays the first.
  function automatic logic [1:0] phase_ab(state_t s, logic dir, logic balk);
    logic [1:0] p1;
    p1 = dir ? EXIT_PH1 : ENTER_PH1;
    return s == PH1 ? p1 :
           s == PH2 ? (dir ? EXIT_PH2 : ENTER_PH2) :
           s == PH3 ? (balk ? p1 : (dir ? EXIT_PH3 : ENTER_PH3)) : 2'b00;
  endfunction
endpackage

// File: rtl/car_emulator_if.sv
// car_emulator_if: command handshake and emulated beam sensor outputs.
interface car_emulator_if #(parameter int DWELL_W = 8);
  logic cmd_valid, cmd_ready, cmd_dir, cmd_balk;
  logic [DWELL_W-1:0] cmd_dwell;
  logic a, b, busy, done;
  modport master(output cmd_valid, cmd_dir, cmd_balk, cmd_dwell, input cmd_ready, a, b, busy, done);
  modport slave(input cmd_valid, cmd_dir, cmd_balk, cmd_dwell, output cmd_ready, a, b, busy, done);
endinterface

// File: rtl/car_emulator_phase_timer.sv
// phase_timer: loadable down-counter that holds at zero.
module phase_timer #(parameter int W = 8) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] count,
  output logic         zero
);
  assign zero = count == '0;
  always_ff @(posedge clk)
    if (reset) count <= '0;
    else if (load) count <= load_value;
    else if (!zero) count <= count - W'(1);
endmodule

// File: rtl/car_emulator.sv
// car_emulator: drives a/b beam sensors through a car enter/exit/balk sequence.
module car_emulator import parking_pkg::*; #(parameter int DWELL_W = 8) (
  input logic clk,
  input logic reset,
  car_emulator_if.slave bus
);
  state_t state, state_n;
  logic dir_q, balk_q, load, zero, accept;
  logic [DWELL_W-1:0] d_q, dwell_in, load_value, count;
  logic [1:0] ab;
  assign dwell_in = bus.cmd_dwell == '0 ? DWELL_W'(1) : bus.cmd_dwell;
  assign bus.cmd_ready = state == IDLE && !reset;
  assign accept = bus.cmd_valid && bus.cmd_ready;
  always_comb begin
    state_n = state;
    load = 1'b0;
    load_value = d_q - DWELL_W'(1);
    if (accept) begin
      state_n = PH1;
      load = 1'b1;
      load_value = dwell_in - DWELL_W'(1);
    end else if (state != IDLE && zero) begin
      state_n = state == PH1 ? PH2 : state == PH2 ? PH3 : state == PH3 ? GAP : IDLE;
      load = state != GAP;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      dir_q <= 1'b0;
      balk_q <= 1'b0;
      d_q <= '0;
      ab <= 2'b00;
    end else begin
      state <= state_n;
      if (accept) begin
        dir_q <= bus.cmd_dir;
        balk_q <= bus.cmd_balk;
        d_q <= dwell_in;
      end
      ab <= phase_ab(state_n, accept ? bus.cmd_dir : dir_q, accept ? bus.cmd_balk : balk_q);
    end
  phase_timer #(.W(DWELL_W)) u_timer (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value), .count(count), .zero(zero)
  );
  assign bus.a = ab[1];
  assign bus.b = ab[0];
  assign bus.busy = state != IDLE;
  assign bus.done = state == GAP && count == '0;
endmodule

// File: tb/tb_car_emulator.sv
// tb_car_emulator: directed checks of beam sequences, handshake timing and reset abort.
module tb_car_emulator;
  logic clk = 1'b0, reset = 1'b1, rst_q = 1'b1;
  int checks = 0, errors = 0, inc_cnt = 0, dec_cnt = 0, done_cnt = 0, hlen = 0;
  logic [5:0] hist = '0;
  logic [1:0] pab;
  car_emulator_if #(.DWELL_W(8)) ifc();
  car_emulator #(.DWELL_W(8)) dut (.clk(clk), .reset(reset), .bus(ifc.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  always @(posedge clk) rst_q <= reset;
  // Reference detector: a full 10,11,01 run counts in, 01,11,10 counts out.
  always @(negedge clk) begin
    if (!rst_q && !$isunknown(pab))
      check("gray", {31'd0, (ifc.a != pab[1]) && (ifc.b != pab[0])}, 0);
    if (ifc.done === 1'b1) done_cnt <= done_cnt + 1;
    if ({ifc.a, ifc.b} !== pab && !$isunknown({ifc.a, ifc.b})) begin
      if ({ifc.a, ifc.b} == 2'b00) begin
        if (hlen == 3 && hist == 6'b10_11_01) inc_cnt <= inc_cnt + 1;
        if (hlen == 3 && hist == 6'b01_11_10) dec_cnt <= dec_cnt + 1;
        hist <= '0;
        hlen <= 0;
      end else begin
        hist <= {hist[3:0], ifc.a, ifc.b};
        hlen <= hlen + 1;
      end
    end
    pab <= {ifc.a, ifc.b};
  end
  task automatic run_cmd(input logic dir, input logic balk, input logic [7:0] dw,
                         input logic [1:0] p1, input logic [1:0] p2, input logic [1:0] p3);
    int d;
    logic [1:0] e;
    d = dw == 0 ? 1 : int'(dw);
    @(negedge clk);
    check("ready_idle", ifc.cmd_ready, 1);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_dir = dir;
    ifc.cmd_balk = balk;
    ifc.cmd_dwell = dw;
    @(posedge clk);
    #1 ifc.cmd_valid = 1'b0;
    for (int i = 0; i < 4 * d; i++) begin
      @(negedge clk);
      e = i < d ? p1 : i < 2 * d ? p2 : i < 3 * d ? p3 : 2'b00;
      check("ab", {ifc.a, ifc.b}, e);
      check("busy", ifc.busy, 1);
      check("done", ifc.done, i == 4 * d - 1);
      check("ready_busy", ifc.cmd_ready, 0);
    end
    @(negedge clk);
    check("busy_end", ifc.busy, 0);
    check("ab_end", {ifc.a, ifc.b}, 0);
    check("done_end", ifc.done, 0);
    check("ready_end", ifc.cmd_ready, 1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int i0, d0, n0, k;
    logic r;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_dir = 1'b0;
    ifc.cmd_balk = 1'b0;
    ifc.cmd_dwell = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", ifc.cmd_ready, 0);
    check("rst_busy", ifc.busy, 0);
    check("rst_ab", {ifc.a, ifc.b}, 0);
    check("rst_done", ifc.done, 0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", ifc.cmd_ready, 1);
    i0 = inc_cnt; d0 = dec_cnt;
    run_cmd(1'b0, 1'b0, 8'd3, 2'b10, 2'b11, 2'b01);
    check("enter_inc", inc_cnt - i0, 1);
    check("enter_dec", dec_cnt - d0, 0);
    i0 = inc_cnt; d0 = dec_cnt;
    run_cmd(1'b1, 1'b0, 8'd0, 2'b01, 2'b11, 2'b10);
    check("exit_inc", inc_cnt - i0, 0);
    check("exit_dec", dec_cnt - d0, 1);
    i0 = inc_cnt; d0 = dec_cnt;
    run_cmd(1'b0, 1'b1, 8'd2, 2'b10, 2'b11, 2'b10);
    check("balk_inc", inc_cnt - i0, 0);
    check("balk_dec", dec_cnt - d0, 0);
    i0 = inc_cnt; d0 = dec_cnt;
    @(negedge clk);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_dir = 1'b0;
    ifc.cmd_balk = 1'b0;
    ifc.cmd_dwell = 8'd1;
    @(posedge clk);
    #1 ifc.cmd_dir = 1'b1;
    k = 21;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      r = ifc.cmd_ready;
      @(posedge clk);
      if (r) begin
        k = j;
        break;
      end
    end
    check("b2b_spacing", k, 5);
    check("b2b_inc_first", inc_cnt - i0, 1);
    check("b2b_dec_first", dec_cnt - d0, 0);
    #1 ifc.cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("b2b_inc", inc_cnt - i0, 1);
    check("b2b_dec", dec_cnt - d0, 1);
    n0 = done_cnt;
    @(negedge clk);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_dir = 1'b0;
    ifc.cmd_dwell = 8'd4;
    @(posedge clk);
    #1 ifc.cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("ph2_ab", {ifc.a, ifc.b}, 2'b11);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ab", {ifc.a, ifc.b}, 0);
    check("abort_busy", ifc.busy, 0);
    check("abort_done", ifc.done, 0);
    check("abort_ready", ifc.cmd_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready_after", ifc.cmd_ready, 1);
    check("abort_no_done", done_cnt - n0, 0);
    i0 = inc_cnt;
    run_cmd(1'b0, 1'b0, 8'd255, 2'b10, 2'b11, 2'b01);
    check("d255_inc", inc_cnt - i0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/car_emulator.md
CAR_EMULATOR -- requirements
Module: car_emulator

Interface
REQ-001 The block SHALL have parameter DWELL_W, default 8, giving the width of the per-phase dwell count.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit: a car command is offered.
REQ-005 The block SHALL have port cmd_ready, output, 1 bit: the block accepts a command this cycle.
REQ-006 The block SHALL have port cmd_dir, input, 1 bit: 0 = enter, 1 = exit.
REQ-007 The block SHALL have port cmd_balk, input, 1 bit: 1 = the car reverses out after reaching the both-blocked phase.
REQ-008 The block SHALL have port cmd_dwell, input, DWELL_W bits: cycles to hold each phase; 0 is treated as 1.
REQ-009 The block SHALL have port a, output, 1 bit: emulated outer beam sensor; 1 = blocked.
REQ-010 The block SHALL have port b, output, 1 bit: emulated inner beam sensor; 1 = blocked.
REQ-011 The block SHALL have port busy, output, 1 bit: a sequence is in progress.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse marking the end of a sequence.

Function
REQ-013 A command SHALL be accepted on a rising edge where cmd_valid=1 and cmd_ready=1; cmd_dir, cmd_balk and D=max(cmd_dwell,1) SHALL be captured on that edge.
REQ-014 cmd_ready SHALL be 1 only in state IDLE with reset=0; the block SHALL ignore cmd_valid in every other state.
REQ-015 The FSM states SHALL be IDLE, PH1, PH2, PH3 and GAP; the transition sequence SHALL be IDLE->PH1->PH2->PH3->GAP->IDLE.
REQ-016 Each of PH1, PH2, PH3 and GAP SHALL last exactly D cycles, timed by a down-counter loaded with D-1 on state entry; the state SHALL advance when the counter is 0.
REQ-017 {a,b} SHALL be driven from registers; the first edge after acceptance SHALL present the PH1 value.
REQ-018 For an enter command, {a,b} SHALL be 10 in PH1, 11 in PH2 and 01 in PH3.
REQ-019 For an exit command, {a,b} SHALL be 01 in PH1, 11 in PH2 and 10 in PH3.
REQ-020 For a balk command, PH3 SHALL repeat the PH1 value (enter 10, exit 01), so that no count is produced downstream.
REQ-021 {a,b} SHALL be 00 in both GAP and IDLE.
REQ-022 busy SHALL be 1 in PH1 through GAP and 0 in IDLE.
REQ-023 done SHALL be 1 for exactly the last GAP cycle, so each command keeps busy high for exactly 4*D cycles.
REQ-024 cmd_ready SHALL rise on the edge after done; the minimum command-to-command spacing SHALL be 4*D+1 cycles.
REQ-025 a and b SHALL never both change on the same edge (Gray-ordered phases), including across sequence boundaries.
REQ-026 With D at its maximum value of 2^DWELL_W-1, the counter SHALL not wrap or overflow.

Reset
REQ-027 On any edge with reset=1, the block SHALL force state=IDLE, counter=0, a=0, b=0, busy=0, done=0 and captured fields=0, and SHALL hold cmd_ready=0.
REQ-028 A reset asserted mid-sequence SHALL abort the sequence with no done pulse, and {a,b} SHALL be 00 on that same edge.
REQ-029 cmd_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-030 A shared package parking_pkg SHALL hold the state enum, the DIR_ENTER/DIR_EXIT constants and the per-direction phase {a,b} pattern constants, for use by this block and the detector bench.
REQ-031 The dwell down-counter SHALL be a sub-module phase_timer (inputs load and load_value; outputs count and zero), DWELL_W bits wide.

Verification
REQ-032 Enter, D=3, balk=0: {a,b} SHALL be 10x3, 11x3, 01x3, 00x3; done SHALL pulse at cycle 12 after acceptance; busy SHALL be high for 12 cycles.
REQ-033 Exit, D=0: {a,b} SHALL be 01, 11, 10, 00, one cycle each; done SHALL pulse on the 4th cycle.
REQ-034 Enter with balk=1, D=2: {a,b} SHALL be 10, 10, 11, 11, 10, 10, 00, 00, and the attached detector SHALL produce no inc and no dec.
REQ-035 cmd_valid held high with enter, then exit, D=1: the second command SHALL be accepted exactly 5 cycles after the first; with the detector attached, the result SHALL be inc=1 once, then dec=1 once.
REQ-036 reset asserted during PH2 of an enter command, D=4: {a,b}=00 and busy=0 on that edge, no done pulse, and cmd_ready=1 one cycle after reset drops.
REQ-037 D=255 with DWELL_W=8: each phase SHALL last exactly 255 cycles, and an assertion SHALL confirm that a and b never toggle on the same edge throughout.
